// File: rtl/decoder_pkg.sv
// Shared widths, FSM state encoding and one-hot helper for decoder_3to8_seq.
package decoder_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// Two-entry in-order FIFO of CODE_W-bit codes; push/pop on the same edge are both honoured.
module code_fifo
    import decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [CODE_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [CODE_W-1:0] dout
);

    logic [CODE_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 one-hot decoder: buffers codes, drives each for HOLD cycles then GAP zeros.
// Optional parity check on accepted codes when DECODER_PARITY_EN is defined.
module decoder_3to8_seq
    import decoder_pkg::*;
#(
    parameter int unsigned HOLD = 4,
    parameter int unsigned GAP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out,
    output logic              out_valid,
    output logic              busy
`ifdef DECODER_PARITY_EN
    ,
    input  logic              in_par,
    output logic              par_err
`endif
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
    localparam bit               HAS_GAP = (GAP > 0);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [OUT_W-1:0]  out_nxt;
    logic              full, empty, pop, push, accept;
    logic [CODE_W-1:0] head;

    assign in_ready = !rst && !full;
    assign accept   = in_valid && in_ready;

`ifdef DECODER_PARITY_EN
    logic par_ok;
    assign par_ok = ~^{in_par, in_code};
    assign push   = accept && par_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_err <= 1'b0;
        else     par_err <= accept && !par_ok;
    end
`else
    assign push = accept;
`endif

    code_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_code),
        .full  (full),
        .empty (empty),
        .dout  (head)
    );

    // Expiry of DRIVE (GAP==0) and of GAP share the IDLE load path so patterns can run back-to-back.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = out;
        pop       = 1'b0;
        if (en) begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        pop       = 1'b1;
                        out_nxt   = onehot(head);
                        cnt_nxt   = HOLD_LD;
                        state_nxt = S_DRIVE;
                    end
                end
                S_DRIVE, S_GAP: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else if (state == S_DRIVE && HAS_GAP) begin
                        out_nxt   = '0;
                        cnt_nxt   = GAP_LD;
                        state_nxt = S_GAP;
                    end else if (!empty) begin
                        pop       = 1'b1;
                        out_nxt   = onehot(head);
                        cnt_nxt   = HOLD_LD;
                        state_nxt = S_DRIVE;
                    end else begin
                        out_nxt   = '0;
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    out_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            out   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            out   <= out_nxt;
        end
    end

    assign out_valid = (state == S_DRIVE);
    assign busy      = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Directed self-checking bench: dut_a uses HOLD=4/GAP=1, dut_b uses HOLD=2/GAP=0.
module tb_decoder_3to8_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, in_valid_a, in_ready_a, out_valid_a, busy_a;
    logic [2:0] in_code_a;
    logic [7:0] out_a;
    logic       en_b, in_valid_b, in_ready_b, out_valid_b, busy_b;
    logic [2:0] in_code_b;
    logic [7:0] out_b;
`ifdef DECODER_PARITY_EN
    logic       in_par_a, par_err_a, in_par_b, par_err_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_3to8_seq #(.HOLD(4), .GAP(1)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .en        (en_a),
        .in_code   (in_code_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .out       (out_a),
        .out_valid (out_valid_a),
        .busy      (busy_a)
`ifdef DECODER_PARITY_EN
        ,
        .in_par    (in_par_a),
        .par_err   (par_err_a)
`endif
    );

    decoder_3to8_seq #(.HOLD(2), .GAP(0)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .en        (en_b),
        .in_code   (in_code_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .out       (out_b),
        .out_valid (out_valid_b),
        .busy      (busy_b)
`ifdef DECODER_PARITY_EN
        ,
        .in_par    (in_par_b),
        .par_err   (par_err_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_code_a(input logic [2:0] c);
        in_code_a = c;
`ifdef DECODER_PARITY_EN
        in_par_a = ^c;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n04, nz, next_code;
        logic       acc, saw_full, started;
        logic [7:0] obs [$];

        rst = 1'b1;
        en_a = 1'b1; in_valid_a = 1'b0; in_code_a = '0;
        en_b = 1'b1; in_valid_b = 1'b0; in_code_b = '0;
`ifdef DECODER_PARITY_EN
        in_par_a = 1'b0; in_par_b = 1'b0;
`endif
        #2;
        check("rst_out", 32'(out_a), 32'h00);
        check("rst_out_valid", 32'(out_valid_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_in_ready", 32'(in_ready_a), 0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("post_rst_ready_a", 32'(in_ready_a), 1);
        check("post_rst_ready_b", 32'(in_ready_b), 1);

        // single code 5
        step();
        set_code_a(3'd5);
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        check("single_latency", 32'(out_a), 32'h00);
        check("single_busy", 32'(busy_a), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("single_hold%0d", i), 32'(out_a), 32'h20);
            check($sformatf("single_valid%0d", i), 32'(out_valid_a), 1);
        end
        step();
        check("single_gap_out", 32'(out_a), 32'h00);
        check("single_gap_valid", 32'(out_valid_a), 0);
        step();
        check("single_busy_fall", 32'(busy_a), 0);
        check("single_idle_out", 32'(out_a), 32'h00);

        // en low for 3 cycles mid-DRIVE on code 2, push 6 while frozen
        set_code_a(3'd2);
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        n04 = 0;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (out_a == 8'h04) n04++;
            if (i == 2) begin
                en_a = 1'b0;
                set_code_a(3'd6);
                in_valid_a = 1'b1;
                check("en_low_ready", 32'(in_ready_a), 1);
            end
            if (i == 3) in_valid_a = 1'b0;
            if (i == 5) en_a = 1'b1;
        end
        check("en_stretch_cycles", 32'(n04), 7);
        check("en_fifo_code", 32'(out_a), 32'h40);
        for (int t = 0; t < 20 && busy_a; t++) step();
        check("drain_a", 32'(busy_a), 0);

        // async reset mid-pattern discards buffered codes
        set_code_a(3'd1);
        in_valid_a = 1'b1;
        step();
        set_code_a(3'd3);
        step();
        set_code_a(3'd7);
        step();
        in_valid_a = 1'b0;
        check("rst_pre_out", 32'(out_a), 32'h02);
        check("full_ready_low", 32'(in_ready_a), 0);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_out", 32'(out_a), 32'h00);
        check("async_rst_valid", 32'(out_valid_a), 0);
        check("async_rst_busy", 32'(busy_a), 0);
        check("async_rst_ready", 32'(in_ready_a), 0);
        step();
        rst = 1'b0;
        nz = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_a != 8'h00 || out_valid_a) nz++;
        end
        check("rst_discard", 32'(nz), 0);

        // back-to-back 0..7 on dut_b, HOLD=2, GAP=0
        next_code = 0;
        in_code_b = 3'd0;
        in_valid_b = 1'b1;
        saw_full = 1'b0;
        started = 1'b0;
        for (int c = 0; c < 80 && obs.size() < 17; c++) begin
            acc = in_valid_b && in_ready_b;
            step();
            if (acc) begin
                next_code++;
                if (next_code == 8) in_valid_b = 1'b0;
                else in_code_b = 3'(next_code);
            end
            if (in_valid_b && !in_ready_b) saw_full = 1'b1;
            if (started || out_b != 8'h00) begin
                started = 1'b1;
                obs.push_back(out_b);
            end
        end
        check("b2b_samples", 32'(obs.size()), 17);
        for (int j = 0; j < obs.size(); j++)
            check($sformatf("b2b_out%0d", j), 32'(obs[j]), (j < 16) ? (32'd1 << (j / 2)) : 32'd0);
        check("b2b_full_seen", 32'(saw_full), 1);

`ifdef DECODER_PARITY_EN
        // bad parity: handshake completes, nothing stored, one-cycle par_err
        in_code_a = 3'd3;
        in_par_a = 1'b1;
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        check("par_err_pulse", 32'(par_err_a), 1);
        check("par_bad_busy", 32'(busy_a), 0);
        step();
        check("par_err_clear", 32'(par_err_a), 0);
        nz = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_a != 8'h00) nz++;
        end
        check("par_bad_no_out", 32'(nz), 0);
        in_code_a = 3'd3;
        in_par_a = 1'b0;
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        check("par_good_no_err", 32'(par_err_a), 0);
        step();
        check("par_good_out", 32'(out_a), 32'h08);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_3to8_seq.md
# decoder_3to8_seq

Sequenced 3-to-8 binary-to-one-hot decoder. It is the receiving-side counterpart to the 8-to-3 encoder. Producers hand it 3-bit codes over a valid/ready handshake. It buffers up to two codes and drives each one as a one-hot pattern for a fixed number of cycles, followed by an optional all-zero gap. Typical use is driving select/strobe lines that must see clean, non-overlapping one-hot pulses.

## Interface
- HOLD, default 4: cycles each one-hot pattern is driven; legal range 1..256.
- GAP, default 1: all-zero cycles after each pattern; legal range 0..256.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- en  input  1  sequencer enable; low freezes the FSM and counters.
- in_code  input  3  binary code to decode.
- in_valid  input  1  in_code is valid.
- in_ready  output  1  buffer can accept; reset value 0 while rst high, 1 after.
- out  output  8  one-hot pattern, 1 << code; reset value 8'h00.
- out_valid  output  1  high while out is driven (state DRIVE); reset value 0.
- busy  output  1  FSM not IDLE or buffer non-empty; reset value 0.
- in_par  input  1  present only with DECODER_PARITY_EN.
- par_err  output  1  present only with DECODER_PARITY_EN; reset value 0.

## Operation
- Accept: a code is taken on a rising edge where in_valid && in_ready.
- in_ready = !full. A full buffer never accepts, even when a pop occurs on the same edge.
- Buffer: 2-entry FIFO, in order.
  - A push and a pop on the same edge are both honoured.
  - Count stays within 0..2.
- FSM states: IDLE, DRIVE, GAP. All transitions below require en=1; with en=0 the state, counter and out hold.
- IDLE, out=0:
  - If FIFO is non-empty: pop, out <= 1 << code, cnt <= HOLD-1, go DRIVE.
- DRIVE, out one-hot:
  - If cnt != 0: cnt--.
  - If cnt == 0 and GAP > 0: out <= 0, cnt <= GAP-1, go GAP.
  - If cnt == 0, GAP == 0 and FIFO non-empty: pop and load the next code back-to-back (stay in DRIVE).
  - If cnt == 0, GAP == 0 and FIFO empty: out <= 0, go IDLE.
- GAP, out=0:
  - If cnt != 0: cnt--.
  - If cnt == 0: behave exactly as IDLE on that edge (load immediately if FIFO non-empty, else go IDLE).
- out is always registered. It is either 0 or exactly one bit set; never glitches between patterns.
- Counter is 8 bits wide. HOLD-1 and GAP-1 fit in 8 bits.
- Reset mid-operation: all outputs clear immediately (asynchronously). FIFO contents and FSM state are discarded.

## Timing
- Latency: a code accepted on edge k into an empty, idle block appears on out after edge k+1.
- Each pattern is visible for exactly HOLD cycles while en=1, followed by exactly GAP zero cycles.
- Throughput with en=1: one code per HOLD+GAP cycles.
- busy falls in the cycle in which the FSM enters IDLE with the FIFO empty.
- en deasserted during DRIVE stretches the pattern by the number of en-low cycles.

## Configuration
- DECODER_PARITY_EN defined:
  - Adds in_par and par_err.
  - Even parity over {in_par, in_code} is checked at acceptance.
  - A bad code completes the handshake but is not stored.
  - par_err pulses high for one cycle, on the edge after acceptance.
- DECODER_PARITY_EN undefined: no in_par or par_err ports; every accepted code is stored.

## Structure
- Package decoder_pkg holds:
  - CODE_W=3, OUT_W=8, CNT_W=8.
  - FSM state encoding: IDLE=2'd0, DRIVE=2'd1, GAP=2'd2.
- Sub-module code_fifo:
  - 2-entry, CODE_W-wide synchronous FIFO on clk with async rst.
  - Exposes push, pop, full, empty, dout.
- Top level contains the FSM, the hold/gap counter and the decode register.

## Test plan
- Reset: with rst high → out=8'h00, out_valid=0, busy=0, in_ready=0. After release → in_ready=1.
- Single code 3'd5, HOLD=4, GAP=1 → out=8'h20 for 4 cycles starting the edge after acceptance, then 8'h00 for 1 cycle; busy then falls.
- Back-to-back 0..7 with in_valid held high, GAP=0, HOLD=2:
  - out walks 01,02,04,…,80 with 2 cycles each and no zero cycles.
  - in_ready drops while the FIFO holds 2 entries.
- en low for 3 cycles mid-DRIVE on code 3'd2 → 8'h04 visible for HOLD+3 cycles; FIFO still accepts while en is low.
- Async rst asserted mid-pattern between clock edges → out=0 immediately; after release, previously buffered codes never appear.
- With DECODER_PARITY_EN: code 3'd3 with in_par=1 → no output, par_err pulses one cycle. Code 3'd3 with in_par=0 → 8'h08 driven.
